// File: rtl/tiger_bridge_pkg.sv
// Shared types and constants for the Tiger uncached data-memory bridge.
package tiger_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  localparam logic [31:0] ERR_READ_VALUE_DEFAULT = 32'h0000_0000;

  // Byte access wins over halfword when the core raises both flags.
  function automatic size_t decode_size(input logic is_byte, input logic is_half);
    if (is_byte)      return SZ_BYTE;
    else if (is_half) return SZ_HALF;
    else              return SZ_WORD;
  endfunction

endpackage

// File: rtl/tiger_lane_steer.sv
// Byte-lane steering: store-side enables and replication, load-side
// extraction with zero extension. Purely combinational.
module tiger_lane_steer
  import tiger_bridge_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] bus_data,
  output logic [3:0]  byteenable,
  output logic [31:0] lane_data,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  // Select lanes from the access size and the low address bits.
  always_comb begin
    byteenable = 4'b1111;
    lane_data  = store_data;
    shifted    = bus_data;
    load_data  = bus_data;
    case (size)
      SZ_BYTE: begin
        byteenable = 4'b0001 << addr_lo;
        lane_data  = {4{store_data[7:0]}};
        shifted    = bus_data >> {addr_lo, 3'b000};
        load_data  = {24'h000000, shifted[7:0]};
      end
      SZ_HALF: begin
        byteenable = addr_lo[1] ? 4'b1100 : 4'b0011;
        lane_data  = {2{store_data[15:0]}};
        shifted    = addr_lo[1] ? {16'h0000, bus_data[31:16]} : bus_data;
        load_data  = {16'h0000, shifted[15:0]};
      end
      default: begin
        byteenable = 4'b1111;
        lane_data  = store_data;
        shifted    = bus_data;
        load_data  = bus_data;
      end
    endcase
  end

endmodule

// File: rtl/tiger_uncached_bridge.sv
// Converts one uncached core load/store into a single Avalon-MM transaction,
// stalling the core until completion and guarding against a dead slave.
module tiger_uncached_bridge
  import tiger_bridge_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter int          TIMEOUT_W      = 11,
  parameter logic [31:0] ERR_READ_VALUE = ERR_READ_VALUE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] memaddress,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] memwritedata,
  input  logic        mem8,
  input  logic        mem16,
  output logic        stall,
  output logic [31:0] readdata,
  output logic        bus_error,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid
);

  state_t               state;
  state_t               state_next;
  size_t                size;
  logic [3:0]           steer_be;
  logic [31:0]          steer_wdata;
  logic [31:0]          steer_rdata;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_expired;
  logic                 capture_read;
  logic                 timed_out;
  logic                 in_read;
  logic                 new_request;

  assign size        = decode_size(mem8, mem16);
  assign wd_expired  = (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign in_read     = (state == ST_RD_REQ) || (state == ST_RD_WAIT);
  assign new_request = (state == ST_IDLE) && (memread || memwrite);

  // The core holds address and size stable while stalled, so the live inputs
  // serve both the request-time lane setup and the capture-time extraction.
  tiger_lane_steer u_lane_steer (
    .size       (size),
    .addr_lo    (memaddress[1:0]),
    .store_data (memwritedata),
    .bus_data   (avm_readdata),
    .byteenable (steer_be),
    .lane_data  (steer_wdata),
    .load_data  (steer_rdata)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // Next-state and strobe decode; completion beats the watchdog in the same cycle.
  always_comb begin
    state_next   = state;
    stall        = 1'b0;
    avm_read     = 1'b0;
    avm_write    = 1'b0;
    capture_read = 1'b0;
    timed_out    = 1'b0;
    case (state)
      ST_IDLE: begin
        stall = memread | memwrite;
        if (memwrite)     state_next = ST_WR_REQ;
        else if (memread) state_next = ST_RD_REQ;
      end
      ST_RD_REQ: begin
        stall    = 1'b1;
        avm_read = 1'b1;
        if (!avm_waitrequest && avm_readdatavalid) begin
          capture_read = 1'b1;
          state_next   = ST_DONE;
        end else if (wd_expired) begin
          timed_out  = 1'b1;
          state_next = ST_DONE;
        end else if (!avm_waitrequest) begin
          state_next = ST_RD_WAIT;
        end
      end
      ST_RD_WAIT: begin
        stall = 1'b1;
        if (avm_readdatavalid) begin
          capture_read = 1'b1;
          state_next   = ST_DONE;
        end else if (wd_expired) begin
          timed_out  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        stall     = 1'b1;
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          state_next = ST_DONE;
        end else if (wd_expired) begin
          timed_out  = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Latch the Avalon request fields when a new core request is taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_address    <= 32'h0;
      avm_byteenable <= 4'h0;
      avm_writedata  <= 32'h0;
    end else if (new_request) begin
      avm_address    <= {memaddress[31:2], 2'b00};
      avm_byteenable <= steer_be;
      avm_writedata  <= steer_wdata;
    end
  end

  // Watchdog: held at zero while idle, counts every busy cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == ST_IDLE) begin
      wd_cnt <= '0;
    end else if (state != ST_DONE) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Load result register; only a finished or timed-out read updates it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= 32'h0;
    end else if (capture_read) begin
      readdata <= steer_rdata;
    end else if (timed_out && in_read) begin
      readdata <= ERR_READ_VALUE;
    end
  end

  // Sticky bus error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       bus_error <= 1'b0;
    else if (timed_out) bus_error <= 1'b1;
  end

endmodule

// File: tb/tb_tiger_uncached_bridge.sv
// Directed self-checking bench for the Tiger uncached bridge.
module tb_tiger_uncached_bridge;

  logic        clk;
  logic        reset_n;
  logic [31:0] memaddress;
  logic        memread;
  logic        memwrite;
  logic [31:0] memwritedata;
  logic        mem8;
  logic        mem16;
  logic        stall;
  logic [31:0] readdata;
  logic        bus_error;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;

  int checks = 0;
  int errors = 0;

  // Per-transaction observations filled in by applyStimulus.
  int          stall_cnt;
  int          rd_cnt;
  int          wr_cnt;
  int          acc_cnt;
  logic [31:0] seen_addr;
  logic [31:0] seen_wd;
  logic [3:0]  seen_be;
  logic        unstable;
  logic        completed;
  logic [31:0] done_rdata;
  logic        done_stall;
  logic [2:0]  after_flags;

  tiger_uncached_bridge #(
    .TIMEOUT_CYCLES (16),
    .TIMEOUT_W      (5)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .memaddress        (memaddress),
    .memread           (memread),
    .memwrite          (memwrite),
    .memwritedata      (memwritedata),
    .mem8              (mem8),
    .mem16             (mem16),
    .stall             (stall),
    .readdata          (readdata),
    .bus_error         (bus_error),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Runs one core request against a scripted slave. wait_cycles is the number
  // of strobe cycles with waitrequest high; valid_delay is cycles after accept
  // until readdatavalid (0 = accept cycle, negative = never).
  task automatic applyStimulus(input logic is_wr, input logic is_rd, input logic [31:0] addr,
                               input logic b8, input logic b16, input logic [31:0] wdata,
                               input int wait_cycles, input int valid_delay,
                               input logic [31:0] slave_data);
    int req_idx;
    int since_acc;
    stall_cnt = 0; rd_cnt = 0; wr_cnt = 0; acc_cnt = 0;
    seen_addr = 32'h0; seen_wd = 32'h0; seen_be = 4'h0;
    unstable = 1'b0; completed = 1'b0; done_rdata = 32'h0; done_stall = 1'b1;
    req_idx = 0; since_acc = -1;
    @(negedge clk);
    memaddress = addr; memread = is_rd; memwrite = is_wr;
    mem8 = b8; mem16 = b16; memwritedata = wdata;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      #1;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      if (!stall) begin
        completed  = 1'b1;
        done_rdata = readdata;
        done_stall = stall;
        break;
      end
      stall_cnt++;
      if (avm_read || avm_write) begin
        if (avm_read)  rd_cnt++;
        if (avm_write) wr_cnt++;
        if (req_idx == 0) begin
          seen_addr = avm_address; seen_be = avm_byteenable; seen_wd = avm_writedata;
        end else if (avm_address !== seen_addr || avm_byteenable !== seen_be ||
                     avm_writedata !== seen_wd) begin
          unstable = 1'b1;
        end
        if (req_idx < wait_cycles) begin
          avm_waitrequest = 1'b1;
        end else begin
          acc_cnt++;
          since_acc = 0;
          if (avm_read && valid_delay == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = slave_data;
          end
        end
        req_idx++;
      end else if (since_acc >= 0) begin
        since_acc++;
        if (since_acc == valid_delay) begin
          avm_readdatavalid = 1'b1;
          avm_readdata = slave_data;
        end
      end
      @(negedge clk);
    end
    if (!completed) $display("[TB] transaction did not complete within bound");
    @(negedge clk);
    memread = 1'b0; memwrite = 1'b0;
    avm_readdatavalid = 1'b0; avm_waitrequest = 1'b0;
    #1;
    after_flags = {avm_read, avm_write, stall};
  endtask

  initial begin
    reset_n = 1'b0;
    memaddress = 32'h0; memread = 1'b0; memwrite = 1'b0; memwritedata = 32'h0;
    mem8 = 1'b0; mem16 = 1'b0;
    avm_readdata = 32'h0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_stall", {31'h0, stall}, 32'h0);
    checkOutput("rst_strobes", {30'h0, avm_read, avm_write}, 32'h0);
    checkOutput("rst_bus_error", {31'h0, bus_error}, 32'h0);
    checkOutput("rst_readdata", readdata, 32'h0);
    checkOutput("rst_address", avm_address, 32'h0);
    checkOutput("rst_be", {28'h0, avm_byteenable}, 32'h0);
    checkOutput("rst_wdata", avm_writedata, 32'h0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Byte store to the top lane.
    applyStimulus(1'b1, 1'b0, 32'h8000_0003, 1'b1, 1'b0, 32'h1234_56AB, 0, -1, 32'h0);
    checkOutput("bst_done", {31'h0, completed}, 32'h1);
    checkOutput("bst_wr_cnt", wr_cnt, 32'd1);
    checkOutput("bst_rd_cnt", rd_cnt, 32'd0);
    checkOutput("bst_addr", seen_addr, 32'h8000_0000);
    checkOutput("bst_be", {28'h0, seen_be}, 32'h8);
    checkOutput("bst_wdata", seen_wd, 32'hABAB_ABAB);
    checkOutput("bst_stall_cycles", stall_cnt, 32'd2);
    checkOutput("bst_after", {29'h0, after_flags}, 32'h0);

    // Halfword store with addr[0] set; the odd bit must be ignored.
    applyStimulus(1'b1, 1'b0, 32'h8000_0021, 1'b0, 1'b1, 32'h0000_BEEF, 1, -1, 32'h0);
    checkOutput("hst_be", {28'h0, seen_be}, 32'h3);
    checkOutput("hst_wdata", seen_wd, 32'hBEEF_BEEF);
    checkOutput("hst_addr", seen_addr, 32'h8000_0020);
    checkOutput("hst_wr_cnt", wr_cnt, 32'd2);
    checkOutput("hst_stall_cycles", stall_cnt, 32'd3);

    // Halfword load from the upper half, data one cycle after accept.
    applyStimulus(1'b0, 1'b1, 32'h8000_0002, 1'b0, 1'b1, 32'h0, 0, 1, 32'h1234_5678);
    checkOutput("hld_be", {28'h0, seen_be}, 32'hC);
    checkOutput("hld_rdata", done_rdata, 32'h0000_1234);
    checkOutput("hld_stall_cycles", stall_cnt, 32'd3);
    checkOutput("hld_rd_cnt", rd_cnt, 32'd1);
    checkOutput("hld_wr_cnt", wr_cnt, 32'd0);

    // Word load with three waitrequest cycles and data in the accept cycle.
    applyStimulus(1'b0, 1'b1, 32'h8000_0008, 1'b0, 1'b0, 32'h0, 3, 0, 32'hDEAD_BEEF);
    checkOutput("wld_rd_cycles", rd_cnt, 32'd4);
    checkOutput("wld_accepts", acc_cnt, 32'd1);
    checkOutput("wld_stable", {31'h0, unstable}, 32'h0);
    checkOutput("wld_addr", seen_addr, 32'h8000_0008);
    checkOutput("wld_be", {28'h0, seen_be}, 32'hF);
    checkOutput("wld_rdata", done_rdata, 32'hDEAD_BEEF);
    checkOutput("wld_stall_cycles", stall_cnt, 32'd5);
    checkOutput("wld_bus_error", {31'h0, bus_error}, 32'h0);

    // Read whose data never arrives: the watchdog ends it after 16 busy cycles.
    applyStimulus(1'b0, 1'b1, 32'h8000_000C, 1'b0, 1'b0, 32'h0, 0, -1, 32'h0);
    checkOutput("to_done", {31'h0, completed}, 32'h1);
    checkOutput("to_stall_cycles", stall_cnt, 32'd17);
    checkOutput("to_rdata", done_rdata, 32'h0);
    checkOutput("to_bus_error", {31'h0, bus_error}, 32'h1);
    repeat (2) @(negedge clk);
    avm_readdata = 32'hFFFF_FFFF;
    avm_readdatavalid = 1'b1;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    checkOutput("late_rdata", readdata, 32'h0);
    checkOutput("late_bus_error", {31'h0, bus_error}, 32'h1);
    checkOutput("late_stall", {31'h0, stall}, 32'h0);

    // Read and write together: only the write goes out.
    applyStimulus(1'b1, 1'b1, 32'h8000_0010, 1'b0, 1'b0, 32'hCAFE_F00D, 0, 0, 32'h5555_5555);
    checkOutput("both_wr_cnt", wr_cnt, 32'd1);
    checkOutput("both_rd_cnt", rd_cnt, 32'd0);
    checkOutput("both_wdata", seen_wd, 32'hCAFE_F00D);
    checkOutput("both_addr", seen_addr, 32'h8000_0010);
    checkOutput("both_after", {29'h0, after_flags}, 32'h0);
    checkOutput("both_rdata_kept", readdata, 32'h0);

    // Byte load from lane 0 so readdata is nonzero before the reset test.
    applyStimulus(1'b0, 1'b1, 32'h8000_0000, 1'b1, 1'b0, 32'h0, 0, 2, 32'hAABB_CC55);
    checkOutput("bld0_rdata", done_rdata, 32'h0000_0055);
    checkOutput("bld0_be", {28'h0, seen_be}, 32'h1);

    // Reset pulse while the bridge sits in RD_WAIT.
    @(negedge clk);
    memaddress = 32'h8000_0004; memread = 1'b1; mem8 = 1'b0; mem16 = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rw_read_low", {31'h0, avm_read}, 32'h0);
    checkOutput("rw_stall", {31'h0, stall}, 32'h1);
    checkOutput("rw_addr", avm_address, 32'h8000_0004);
    #1;
    reset_n = 1'b0;
    memread = 1'b0;
    #1;
    checkOutput("ar_stall", {31'h0, stall}, 32'h0);
    checkOutput("ar_strobes", {30'h0, avm_read, avm_write}, 32'h0);
    checkOutput("ar_readdata", readdata, 32'h0);
    checkOutput("ar_bus_error", {31'h0, bus_error}, 32'h0);
    checkOutput("ar_address", avm_address, 32'h0);
    checkOutput("ar_be", {28'h0, avm_byteenable}, 32'h0);
    checkOutput("ar_wdata", avm_writedata, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    avm_readdata = 32'h1111_1111;
    avm_readdatavalid = 1'b1;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    checkOutput("post_rst_late", readdata, 32'h0);

    // Fresh byte load after reset.
    applyStimulus(1'b0, 1'b1, 32'h8000_0001, 1'b1, 1'b0, 32'h0, 0, 1, 32'hCAFE_BE42);
    checkOutput("bld1_done", {31'h0, completed}, 32'h1);
    checkOutput("bld1_be", {28'h0, seen_be}, 32'h2);
    checkOutput("bld1_rdata", done_rdata, 32'h0000_00BE);
    checkOutput("bld1_done_stall", {31'h0, done_stall}, 32'h0);
    checkOutput("bld1_stall_cycles", stall_cnt, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard so the bench always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got hang, expected finish");
    $fatal(1, "[TB] global time limit reached");
  end

endmodule
